// File: rtl/spatz_lane_operand_stage.sv
// spatz_lane_operand_stage
// Collects the s1/s2/d operand streams read from the VRF, one element at a
// time, into per-operand holding registers. It then hands complete operand
// bundles to the SIMD lane through a small issue FIFO.
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   start_i, op_i, vl_i, use_i,
//   is_signed_i                       instruction launch + attributes
//                                     (use_i = {d,s2,s1} operand-used mask)
//   flush_i                           synchronous abort
//   busy_o, done_o                    in flight / one-cycle completion pulse
//   {s1,s2,d}_valid_i/_i/_ready_o     VRF read-stream handshakes
//   issue_*                           operand bundle to the lane (valid/ready)
//
// Optional feature: define SPATZ_OPSTAGE_SCALAR_EN to add scalar_en_i and
// scalar_i. When scalar_en_i is latched high at start, s1 is replaced by a
// scalar that is broadcast to every element.

package spatz_opstage_pkg;
  typedef enum logic [2:0] {
    OP_VADD = 3'd0, OP_VSUB, OP_VMUL, OP_VMACC, OP_VAND, OP_VOR, OP_VXOR, OP_VMV
  } op_e;
endpackage

module spatz_lane_operand_stage
  import spatz_opstage_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  op_e              op_i,
  input  logic [15:0]      vl_i,
  input  logic [2:0]       use_i,
  input  logic             is_signed_i,
`ifdef SPATZ_OPSTAGE_SCALAR_EN
  input  logic             scalar_en_i,
  input  logic [Width-1:0] scalar_i,
`endif
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             s1_valid_i,
  input  logic [Width-1:0] s1_i,
  output logic             s1_ready_o,
  input  logic             s2_valid_i,
  input  logic [Width-1:0] s2_i,
  output logic             s2_ready_o,
  input  logic             d_valid_i,
  input  logic [Width-1:0] d_i,
  output logic             d_ready_o,
  output logic             issue_valid_o,
  input  logic             issue_ready_i,
  output logic [Width-1:0] issue_s1_o,
  output logic [Width-1:0] issue_s2_o,
  output logic [Width-1:0] issue_d_o,
  output op_e              issue_op_o,
  output logic             issue_is_signed_o,
  output logic             issue_last_o
);

  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2;
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);

  typedef struct packed {
    logic [Width-1:0] s1;
    logic [Width-1:0] s2;
    logic [Width-1:0] d;
    op_e              op;
    logic             sgn;
    logic             last;
  } bundle_t;

  logic [1:0]       state;
  op_e              op_q;
  logic [15:0]      vl_q, cnt_q;
  logic [2:0]       use_q;
  logic             sgn_q, done_q;
  logic [Width-1:0] hold_s1, hold_s2, hold_d;
  logic             full_s1, full_s2, full_d;
  logic             scalar_en_q;
  logic [Width-1:0] s1_data;

  bundle_t          mem [Depth];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fcnt;

  logic    collect, all_full, push, pop, last, fifo_empty;
  logic    xfer_s1, xfer_s2, xfer_d;
  bundle_t push_b, head;

`ifdef SPATZ_OPSTAGE_SCALAR_EN
  logic [Width-1:0] scalar_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scalar_en_q <= 1'b0;
      scalar_q    <= '0;
    end else if (state == IDLE && start_i && !flush_i) begin
      scalar_en_q <= scalar_en_i;
      scalar_q    <= scalar_i;
    end
  end
  assign s1_data = scalar_en_q ? scalar_q : hold_s1;
`else
  assign scalar_en_q = 1'b0;
  assign s1_data     = hold_s1;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    collect    = (state == COLLECT);
    fifo_empty = (fcnt == '0);
    pop        = !fifo_empty && issue_ready_i;
    // Unused operands and a broadcast scalar never block a bundle.
    all_full   = (full_s1 | ~use_q[0] | scalar_en_q) &
                 (full_s2 | ~use_q[1]) & (full_d | ~use_q[2]);
    push       = collect && all_full && ((fcnt < CW'(Depth)) || pop);
    last       = (cnt_q == vl_q - 16'd1);
    // Ready may rise while the register is full if this cycle's push empties it.
    s1_ready_o = collect && use_q[0] && !scalar_en_q && (!full_s1 || push);
    s2_ready_o = collect && use_q[1] && (!full_s2 || push);
    d_ready_o  = collect && use_q[2] && (!full_d || push);
    xfer_s1    = s1_valid_i && s1_ready_o;
    xfer_s2    = s2_valid_i && s2_ready_o;
    xfer_d     = d_valid_i && d_ready_o;
    push_b.s1   = use_q[0] ? s1_data : '0;
    push_b.s2   = use_q[1] ? hold_s2 : '0;
    push_b.d    = use_q[2] ? hold_d : '0;
    push_b.op   = op_q;
    push_b.sgn  = sgn_q;
    push_b.last = last;
    head        = mem[rd_ptr];
  end

  // Control, attributes and operand holding registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      op_q    <= OP_VADD;
      vl_q    <= '0;
      use_q   <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      full_s1 <= 1'b0;
      full_s2 <= 1'b0;
      full_d  <= 1'b0;
      hold_s1 <= '0;
      hold_s2 <= '0;
      hold_d  <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      full_s1 <= 1'b0;
      full_s2 <= 1'b0;
      full_d  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          op_q  <= op_i;
          vl_q  <= vl_i;
          use_q <= use_i;
          sgn_q <= is_signed_i;
          cnt_q <= '0;
          if (vl_i != 16'd0) state <= COLLECT;
          else done_q <= 1'b1;
        end
        COLLECT: if (push) begin
          cnt_q <= cnt_q + 16'd1;
          if (last) state <= DRAIN;
        end
        DRAIN: if (fifo_empty) begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // A refill in the same cycle as a push keeps the flag set.
      if (xfer_s1) begin full_s1 <= 1'b1; hold_s1 <= s1_i; end
      else if (push) full_s1 <= 1'b0;
      if (xfer_s2) begin full_s2 <= 1'b1; hold_s2 <= s2_i; end
      else if (push) full_s2 <= 1'b0;
      if (xfer_d) begin full_d <= 1'b1; hold_d <= d_i; end
      else if (push) full_d <= 1'b0;
    end
  end

  // Issue FIFO: registered only, so an empty FIFO adds a full cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_b;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end
  end

  // Stale entries left in the FIFO are masked so idle outputs read as zero.
  assign issue_valid_o     = !fifo_empty;
  assign issue_s1_o        = fifo_empty ? '0 : head.s1;
  assign issue_s2_o        = fifo_empty ? '0 : head.s2;
  assign issue_d_o         = fifo_empty ? '0 : head.d;
  assign issue_op_o        = fifo_empty ? OP_VADD : head.op;
  assign issue_is_signed_o = !fifo_empty && head.sgn;
  assign issue_last_o      = !fifo_empty && head.last;
  assign busy_o            = (state != IDLE);
  assign done_o            = done_q;

endmodule

// File: tb/tb_spatz_lane_operand_stage.sv
module tb_spatz_lane_operand_stage;
  import spatz_opstage_pkg::*;

  logic        clk = 0, rst = 1;
  logic        start = 0, sg = 0, flush = 0;
  op_e         op = OP_VADD;
  logic [15:0] vl = 0;
  logic [2:0]  use_m = 0;
  logic        busy, done;
  logic        s1_valid = 0, s2_valid = 0, d_valid = 0;
  logic [31:0] s1 = 0, s2 = 0, d = 0;
  logic        s1_ready, s2_ready, d_ready;
  logic        issue_valid, issue_ready = 1, issue_sg, issue_last;
  logic [31:0] issue_s1, issue_s2, issue_d;
  op_e         issue_op;
  logic        scalar_en = 0;
  logic [31:0] scalar = 0;

  always #5 clk = ~clk;

  spatz_lane_operand_stage dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .vl_i(vl),
    .use_i(use_m), .is_signed_i(sg),
`ifdef SPATZ_OPSTAGE_SCALAR_EN
    .scalar_en_i(scalar_en), .scalar_i(scalar),
`endif
    .flush_i(flush), .busy_o(busy), .done_o(done),
    .s1_valid_i(s1_valid), .s1_i(s1), .s1_ready_o(s1_ready),
    .s2_valid_i(s2_valid), .s2_i(s2), .s2_ready_o(s2_ready),
    .d_valid_i(d_valid), .d_i(d), .d_ready_o(d_ready),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
    .issue_s1_o(issue_s1), .issue_s2_o(issue_s2), .issue_d_o(issue_d),
    .issue_op_o(issue_op), .issue_is_signed_o(issue_sg), .issue_last_o(issue_last)
  );

  typedef struct {
    logic [31:0] s1, s2, d;
    op_e op;
    logic sg, last;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0, fails = 0, rx = 0;
  logic [31:0] s1_arr[16], s2_arr[16], d_arr[16];
  logic        abort_drv = 0, s1r_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every bundle accepted by the lane.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      exp_t e;
      rx++;
      chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_s1", issue_s1, e.s1);
        chk("issue_s2", issue_s2, e.s2);
        chk("issue_d", issue_d, e.d);
        chk("issue_op", issue_op, e.op);
        chk("issue_sg", issue_sg, e.sg);
        chk("issue_last", issue_last, e.last);
      end
    end
    if (s1_ready) s1r_seen = 1;
  end

  task automatic expect_bundles(input int n, input logic [2:0] u, input op_e o,
                                input logic sgn, input logic sc_en, input logic [31:0] sc);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.s1 = !u[0] ? 32'd0 : (sc_en ? sc : s1_arr[i]);
      e.s2 = u[1] ? s2_arr[i] : 32'd0;
      e.d  = u[2] ? d_arr[i] : 32'd0;
      e.op = o; e.sg = sgn; e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int n, input logic [2:0] u, input op_e o, input logic sgn);
    start = 1; vl = 16'(n); use_m = u; op = o; sg = sgn;
    @(posedge clk); #1;
    start = 0;
  endtask

  // Streams element data on the used operands, each held until accepted.
  task automatic drive(input int n, input logic [2:0] u);
    int i1 = 0, i2 = 0, id = 0, guard = 0;
    logic r1, r2, rd;
    while (((u[0] && i1 < n) || (u[1] && i2 < n) || (u[2] && id < n)) &&
           guard < 200 && !abort_drv) begin
      s1_valid = u[0] && i1 < n; s1 = s1_arr[i1];
      s2_valid = u[1] && i2 < n; s2 = s2_arr[i2];
      d_valid  = u[2] && id < n; d  = d_arr[id];
      @(negedge clk);
      r1 = s1_valid && s1_ready; r2 = s2_valid && s2_ready; rd = d_valid && d_ready;
      @(posedge clk); #1;
      if (r1) i1++;
      if (r2) i2++;
      if (rd) id++;
      guard++;
    end
    s1_valid = 0; s2_valid = 0; d_valid = 0;
    chk("drive_timeout", 64'(guard < 200), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int guard = 0;
    while (guard < 100) begin
      @(negedge clk);
      if (done) break;
      guard++;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 1'b0);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int rx0, guard;
    logic bad;
    // Reset state
    #2;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_ivalid", issue_valid, 0);
    chk("rst_ready", {s1_ready, s2_ready, d_ready}, 0);
    chk("rst_idata", {issue_s1, issue_s2, issue_d}, 0);
    chk("rst_iattr", {issue_op, issue_sg, issue_last}, 0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
    chk("post_rst_ready", {s1_ready, s2_ready, d_ready}, 0);

    // Operand-accept to issue_valid latency with an empty FIFO
    s1_arr[0] = 32'h77;
    expect_bundles(1, 3'b001, OP_VMUL, 1'b1, 1'b0, 0);
    do_start(1, 3'b001, OP_VMUL, 1'b1);
    s1_valid = 1; s1 = 32'h77;
    @(negedge clk); chk("lat_ready", s1_ready, 1);
    chk("lat_s2_unused_ready", s2_ready, 0);
    @(posedge clk); #1; s1_valid = 0;
    @(negedge clk); chk("lat_ivalid_1cyc", issue_valid, 0);
    @(negedge clk); chk("lat_ivalid_2cyc", issue_valid, 1);
    wait_done("lat");

    // vl=4, use=011, back-to-back
    for (int i = 0; i < 4; i++) begin
      s1_arr[i] = 32'(i + 1); s2_arr[i] = 32'(10 * (i + 1)); d_arr[i] = 32'hdead;
    end
    expect_bundles(4, 3'b011, OP_VADD, 1'b0, 1'b0, 0);
    rx0 = rx;
    do_start(4, 3'b011, OP_VADD, 1'b0);
    chk("b2b_busy", busy, 1);
    drive(4, 3'b011);
    wait_done("b2b");
    chk("b2b_count", 64'(rx - rx0), 64'd4);

    // vl=3 use=111, lane stalled for 10 cycles
    issue_ready = 0;
    for (int i = 0; i < 3; i++) begin
      s1_arr[i] = 32'(100 + i); s2_arr[i] = 32'(200 + i); d_arr[i] = 32'(300 + i);
    end
    expect_bundles(3, 3'b111, OP_VMACC, 1'b1, 1'b0, 0);
    do_start(3, 3'b111, OP_VMACC, 1'b1);
    drive(3, 3'b111);
    start = 1; vl = 16'd5;           // must be ignored while busy
    @(negedge clk);
    chk("stall_ready", {s1_ready, s2_ready, d_ready}, 0);
    chk("stall_ivalid", issue_valid, 1);
    chk("stall_head", issue_s1, 32'd100);
    @(posedge clk); #1; start = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("stall_head_stable", issue_d, 32'd300);
    chk("stall_ready_late", {s1_ready, s2_ready, d_ready}, 0);
    issue_ready = 1;
    wait_done("stall");

    // vl=0
    do_start(0, 3'b011, OP_VSUB, 1'b0);
    @(negedge clk);
    chk("vl0_done", done, 1); chk("vl0_busy", busy, 0);
    chk("vl0_ivalid", issue_valid, 0);
    @(negedge clk); chk("vl0_done_once", done, 0);
    @(posedge clk); #1;

    // flush during the 3rd bundle
    for (int i = 0; i < 8; i++) begin s1_arr[i] = 32'(i); s2_arr[i] = 32'(50 + i); end
    expect_bundles(8, 3'b011, OP_VXOR, 1'b0, 1'b0, 0);
    rx0 = rx;
    do_start(8, 3'b011, OP_VXOR, 1'b0);
    abort_drv = 0;
    fork
      drive(8, 3'b011);
      begin
        guard = 0;
        while (rx - rx0 < 2 && guard < 100) begin @(posedge clk); #1; guard++; end
        chk("flush_reach_3rd", 64'(guard < 100), 64'd1);
        flush = 1; abort_drv = 1;
        @(posedge clk); #1;
        flush = 0; exp_q.delete();
      end
    join
    abort_drv = 0;
    @(negedge clk);
    chk("flush_busy", busy, 0); chk("flush_ivalid", issue_valid, 0);
    bad = 0;
    repeat (6) begin @(negedge clk); bad |= done | issue_valid; end
    chk("flush_no_done", bad, 0);
    @(posedge clk); #1;
    s1_arr[0] = 32'h11; s2_arr[0] = 32'h22;
    expect_bundles(1, 3'b011, OP_VOR, 1'b0, 1'b0, 0);
    do_start(1, 3'b011, OP_VOR, 1'b0);
    drive(1, 3'b011);
    wait_done("post_flush");

    // reset mid-COLLECT with two entries queued
    issue_ready = 0;
    for (int i = 0; i < 4; i++) begin s1_arr[i] = 32'(7 + i); s2_arr[i] = 32'(9 + i); end
    do_start(4, 3'b011, OP_VAND, 1'b1);
    drive(3, 3'b011);
    @(negedge clk); chk("pre_rst_ivalid", issue_valid, 1);
    @(posedge clk); #3; rst = 1; #1;
    chk("arst_busy", busy, 0); chk("arst_ivalid", issue_valid, 0);
    chk("arst_idata", {issue_s1, issue_s2, issue_last, issue_sg}, 0);
    chk("arst_ready", {s1_ready, s2_ready, d_ready}, 0);
    exp_q.delete();
    @(posedge clk); #1; rst = 0; issue_ready = 1;
    bad = 0;
    repeat (5) begin @(negedge clk); bad |= done | busy | issue_valid; end
    chk("arst_quiet", bad, 0);
    @(posedge clk); #1;

`ifdef SPATZ_OPSTAGE_SCALAR_EN
    for (int i = 0; i < 3; i++) s2_arr[i] = 32'(i + 1);
    expect_bundles(3, 3'b011, OP_VADD, 1'b0, 1'b1, 32'h5A);
    scalar_en = 1; scalar = 32'h5A; s1r_seen = 0;
    do_start(3, 3'b011, OP_VADD, 1'b0);
    scalar_en = 0; scalar = 0;
    drive(3, 3'b010);
    wait_done("scalar");
    chk("scalar_s1_ready", s1r_seen, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
